// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_fifo
// Brief    : Receive-side byte buffer between the receiver's byte-ready
//            strobe and the host read interface. Single-clock FIFO with
//            show-ahead read data, occupancy count and a sticky overrun
//            flag that records bytes dropped while the buffer is full.
// Revision : 1.0 - initial release
// ============================================================================
module rx_fifo #(
    parameter int DEPTH     = 8,   // number of byte entries, power of two, >= 2
    parameter int ADDR_BITS = 3    // log2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 write_enable,
    input  logic [7:0]           write_data,
    input  logic                 read_enable,
    input  logic                 clear_overrun,
    output logic [7:0]           read_data,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic [ADDR_BITS:0]   fifo_count,
    output logic                 overrun
);

    localparam logic [ADDR_BITS:0]   c_FULL_COUNT = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   c_CNT_ONE    = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] c_PTR_ONE    = ADDR_BITS'(1);

    logic [7:0]           r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wptr;
    logic [ADDR_BITS-1:0] r_rptr;
    logic [ADDR_BITS:0]   r_count;
    logic                 r_overrun;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_wr_accept;
    logic                 w_rd_accept;
    logic                 w_drop;

    // Flags come from the registered count, so they follow an operation by one edge
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_COUNT);

    // A write into a full buffer is still accepted when the head is popped in
    // the same cycle; a read of an empty buffer is silently ignored
    assign w_wr_accept = write_enable & (~w_full | read_enable);
    assign w_rd_accept = read_enable & ~w_empty;
    assign w_drop      = write_enable & w_full & ~read_enable;

    // Storage array; contents are not reset since pointers define validity
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wptr] <= write_data;
        end
    end

    // Write pointer advances with natural modulo-DEPTH wrap
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr <= '0;
        end else if (w_wr_accept) begin
            r_wptr <= r_wptr + c_PTR_ONE;
        end
    end

    // Read pointer advances only when a byte actually leaves
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rptr <= '0;
        end else if (w_rd_accept) begin
            r_rptr <= r_rptr + c_PTR_ONE;
        end
    end

    // Occupancy: push-only increments, pop-only decrements, both or neither hold
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overrun; a new drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clear_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    // Show-ahead head byte, forced to zero while nothing is buffered
    assign read_data  = w_empty ? 8'h00 : r_mem[r_rptr];
    assign fifo_empty = w_empty;
    assign fifo_full  = w_full;
    assign fifo_count = r_count;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_fifo
// Brief    : Self-checking bench for rx_fifo: a table of directed vectors
//            with hand-computed expected outputs, followed by hand-written
//            sequences for asynchronous reset, pointer wrap-around and
//            reset in the middle of a stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_fifo;

    logic       clk;
    logic       n_rst;
    logic       write_enable;
    logic [7:0] write_data;
    logic       read_enable;
    logic       clear_overrun;
    logic [7:0] read_data;
    logic       fifo_empty;
    logic       fifo_full;
    logic [3:0] fifo_count;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       clr;
        logic [7:0] e_rd;
        logic       e_empty;
        logic       e_full;
        logic [3:0] e_cnt;
        logic       e_ovr;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] model_q[$];

    rx_fifo #(
        .DEPTH     (8),
        .ADDR_BITS (3)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .write_enable  (write_enable),
        .write_data    (write_data),
        .read_enable   (read_enable),
        .clear_overrun (clear_overrun),
        .read_data     (read_data),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .fifo_count    (fifo_count),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] rd, input logic emp,
                           input logic full, input logic [3:0] cnt, input logic ovr);
        chk({tag, " read_data"},  read_data,       rd);
        chk({tag, " fifo_empty"}, 8'(fifo_empty),  8'(emp));
        chk({tag, " fifo_full"},  8'(fifo_full),   8'(full));
        chk({tag, " fifo_count"}, 8'(fifo_count),  8'(cnt));
        chk({tag, " overrun"},    8'(overrun),     8'(ovr));
    endtask

    function automatic void add(input logic we, input logic [7:0] wd, input logic re,
                                input logic clr, input logic [7:0] rd, input logic emp,
                                input logic full, input logic [3:0] cnt, input logic ovr);
        vec_t v;
        v.we = we; v.wd = wd; v.re = re; v.clr = clr;
        v.e_rd = rd; v.e_empty = emp; v.e_full = full; v.e_cnt = cnt; v.e_ovr = ovr;
        vecs.push_back(v);
    endfunction

    // One clock cycle: drive on the falling edge, sample just after the rising edge
    task automatic cycle(input logic we, input logic [7:0] wd, input logic re, input logic clr);
        @(negedge clk);
        write_enable  = we;
        write_data    = wd;
        read_enable   = re;
        clear_overrun = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        write_enable  = 1'b0;
        write_data    = 8'h00;
        read_enable   = 1'b0;
        clear_overrun = 1'b0;
    endtask

    initial begin
        logic [7:0] b;

        // ---------------- vector table ----------------
        // fill A1..A8
        for (int k = 1; k <= 8; k++)
            add(1'b1, 8'(8'hA0 + k), 1'b0, 1'b0, 8'hA1, 1'b0, (k == 8), 4'(k), 1'b0);
        // dropped write sets overrun, count stays 8
        add(1'b1, 8'hFF, 1'b0, 1'b0, 8'hA1, 1'b0, 1'b1, 4'd8, 1'b1);
        // clear overrun
        add(1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 4'd8, 1'b0);
        // drop and clear together: set wins
        add(1'b1, 8'hEE, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 4'd8, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 4'd8, 1'b0);
        // full with write+read: A1 leaves, 55 enters, no overrun
        add(1'b1, 8'h55, 1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, 4'd8, 1'b0);
        // drain: A2..A8 then 55 emerges last
        for (int i = 1; i <= 8; i++)
            add(1'b0, 8'h00, 1'b1, 1'b0,
                (i <= 6) ? 8'(8'hA2 + i) : ((i == 7) ? 8'h55 : 8'h00),
                (i == 8), 1'b0, 4'(8 - i), 1'b0);
        // read on empty is harmless
        add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);
        // empty with write+read: only the write is taken
        add(1'b1, 8'h66, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 4'd1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);

        // ---------------- reset then idle ----------------
        n_rst         = 1'b0;
        write_enable  = 1'b0;
        write_data    = 8'h00;
        read_enable   = 1'b0;
        clear_overrun = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);
        n_rst = 1'b1;

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            cycle(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_empty,
                    vecs[i].e_full, vecs[i].e_cnt, vecs[i].e_ovr);
        end
        idle_inputs();

        // ---------------- wrap-around with 3-entry offset ----------------
        model_q.delete();
        for (int k = 0; k < 3; k++) begin
            b = 8'(8'h10 + k);
            cycle(1'b1, b, 1'b0, 1'b0);
            model_q.push_back(b);
        end
        chk("wrap prefill count", 8'(fifo_count), 8'd3);
        for (int i = 0; i < 20; i++) begin
            b = 8'(8'h20 + i);
            cycle(1'b1, b, 1'b0, 1'b0);
            model_q.push_back(b);
            chk($sformatf("wrap%0d count after write", i), 8'(fifo_count), 8'd4);
            chk($sformatf("wrap%0d head", i), read_data, model_q[0]);
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            void'(model_q.pop_front());
            chk($sformatf("wrap%0d count after read", i), 8'(fifo_count), 8'd3);
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("wrap drain%0d head", k), read_data, model_q[0]);
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            void'(model_q.pop_front());
        end
        chk("wrap drained empty", 8'(fifo_empty), 8'd1);
        idle_inputs();

        // ---------------- reset mid-stream (asynchronous) ----------------
        for (int k = 0; k < 5; k++)
            cycle(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
        idle_inputs();
        chk("midrst pre count", 8'(fifo_count), 8'd5);
        #2;
        n_rst = 1'b0;
        #1;
        chk_all("midrst async", 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        chk_all("midrst new write", 8'h77, 1'b0, 1'b0, 4'd1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk_all("midrst new read", 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
- Receive-side byte buffer for the serial link datapath: the receiver core writes each decoded byte, and the host-side logic reads them out.
- 8-deep single-clock FIFO with its own storage, pointers and occupancy count.
- Adds a sticky overrun flag so that bytes dropped while the FIFO is full are reported to the host.
- Sits between the receiver's byte-ready strobe and the host read interface, mirroring the transmit buffer on the outgoing path.

Parameters:
- DEPTH, 8, number of byte entries; must be a power of two, minimum 2.
- ADDR_BITS, 3, log2(DEPTH); width of the read and write pointers.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- write_enable  input  1  receiver strobe: push write_data this cycle.
- write_data  input  8  received byte.
- read_enable  input  1  host strobe: pop the head entry this cycle.
- clear_overrun  input  1  synchronous clear of the overrun flag.
- read_data  output  8  head entry (show-ahead); 8'h00 when empty.
- fifo_empty  output  1  high when count == 0.
- fifo_full  output  1  high when count == DEPTH.
- fifo_count  output  ADDR_BITS+1  current occupancy, 0..DEPTH.
- overrun  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (n_rst low, asynchronous): wptr=0, rptr=0, count=0, overrun=0. Outputs become fifo_empty=1, fifo_full=0, fifo_count=0, read_data=8'h00. Storage contents need not be cleared.
- Reset mid-operation: all buffered data is discarded immediately, with no wait for a clock edge.
- Storage: DEPTH x 8 register array, written on the clock edge.
- read_data is combinational from mem[rptr], so zero read latency. It is forced to 8'h00 while fifo_empty=1.
- Write accepted = write_enable & (~fifo_full | read_enable).
  - On accept: mem[wptr] <= write_data, and wptr advances by 1 modulo DEPTH (natural wrap from DEPTH-1 to 0).
- Read accepted = read_enable & ~fifo_empty.
  - On accept: rptr advances by 1 modulo DEPTH.
  - The popped byte is the one on read_data in the same cycle as read_enable.
- Count update:
  - +1 on write-only.
  - -1 on read-only.
  - Unchanged on simultaneous accepted read and write, or on no operation.
- Flags fifo_full and fifo_empty are decoded from the registered count. They update the cycle after the operation that changes the count.
- Boundary: full with write and read in the same cycle. Both are accepted, the head byte leaves, the new byte enters, count stays DEPTH, and overrun is not set.
- Boundary: full with write only. The byte is dropped, with no pointer or count change, and overrun is set to 1 at the next edge.
- Boundary: empty with read_enable. The read is ignored, rptr is unchanged, and there is no error flag (underflow is harmless).
- Boundary: empty with write and read in the same cycle. Only the write is accepted, and count becomes 1. There is no fall-through in the same cycle.
- overrun is sticky until clear_overrun=1 at a clock edge, which clears it.
  - If clear_overrun and a new dropped write occur in the same cycle, the set wins and overrun remains 1.
- Arithmetic: pointers are ADDR_BITS wide with unsigned wrap. count is ADDR_BITS+1 wide and never exceeds DEPTH or drops below 0.

Test Plan:
- Reset then idle:
  - Stimulus: assert n_rst=0 for 2 cycles, release.
  - Required: fifo_empty=1, fifo_full=0, fifo_count=0, read_data=8'h00, overrun=0.
  - Also assert n_rst low between clock edges and check the outputs clear immediately.
- Ordered fill and drain:
  - Stimulus: write 8'hA1..8'hA8 on 8 consecutive cycles.
  - Required: fifo_full=1 and fifo_count=8 after the 8th edge.
  - Stimulus: then pop 8 times.
  - Required: read_data shows A1..A8 in order, fifo_empty=1 after the last pop.
- Overrun:
  - Stimulus: with the FIFO full, write 8'hFF without read.
  - Required: overrun=1, fifo_count stays 8, the next reads still return A1..A8 (FF absent).
  - Stimulus: pulse clear_overrun.
  - Required: overrun=0.
  - Stimulus: repeat with clear_overrun and the dropped write in the same cycle.
  - Required: overrun stays 1.
- Simultaneous read/write:
  - Stimulus: at count=8, assert write 8'h55 and read together.
  - Required: count stays 8, overrun=0, and 8'h55 emerges last.
  - Stimulus: at count=0, assert both with 8'h66.
  - Required: count=1 and read_data=8'h66 the next cycle.
- Wrap-around:
  - Stimulus: 20 interleaved write/read pairs offset by 3 entries, so the pointers wrap twice.
  - Required: all bytes return in order and fifo_count oscillates only between 3 and 4.
- Reset mid-stream:
  - Stimulus: with 5 entries buffered, pulse n_rst low.
  - Required: count=0 and fifo_empty=1 immediately, and the next write/read returns only the new byte.
